spi_apb_slave: RTL and testbench

//  APB3/4 completer sitting downstream of the system APB bus: consumes one psel line plus shared paddr/pwdata/pwrite/penable/pstrb/pprot.

---
 rtl/spi_apb_pkg.sv | 31 +++
 rtl/spi_apb_access_fsm.sv | 65 ++++++
 rtl/spi_apb_slave.sv | 162 ++++++++++++++++
 tb/tb_spi_apb_slave.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_apb_pkg.sv
// rtl/spi_apb_pkg.sv - register map, bit positions and access FSM states for the SPI APB completer
package spi_apb_pkg;

  // Register word index (paddr[3:2])
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_RXDATA = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_CPOL    = 1;
  localparam int CTRL_CPHA    = 2;
  localparam int CTRL_TXIE    = 3;
  localparam int CTRL_RXIE    = 4;
  localparam int CTRL_LOW_W   = 5;
  localparam int CTRL_DIV_LSB = 8;

  // STATUS bit positions
  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_RX_EMPTY = 1;
  localparam int STAT_BUSY     = 2;
  localparam int STAT_RX_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_e;

endpackage

// File: rtl/spi_apb_access_fsm.sv
// rtl/spi_apb_access_fsm.sv - APB access sequencing: pready, rx_pop and completion pulse
module spi_apb_access_fsm
  import spi_apb_pkg::*;
(
  input  logic pclk,
  input  logic preset_n,
  input  logic psel,
  input  logic penable,
  input  logic rd_wait_req,
  output logic pready,
  output logic rx_pop,
  output logic complete,
  output logic in_rdwait
);

  state_e state_q, state_d;

  // State register; reset returns to IDLE immediately so strobes drop at once
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle outputs; a qualifying RXDATA read pops in its first
  // access cycle and completes one cycle later once the FIFO output has settled
  always_comb begin
    state_d = state_q;
    pready  = 1'b0;
    rx_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          if (rd_wait_req) begin
            rx_pop  = 1'b1;
            state_d = RDWAIT;
          end else begin
            pready  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      RDWAIT: begin
        pready  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign complete  = psel & penable & pready;
  assign in_rdwait = (state_q == RDWAIT);

endmodule

// File: rtl/spi_apb_slave.sv
// rtl/spi_apb_slave.sv - APB completer exposing SPI control, status, TX push and RX pop
module spi_apb_slave
  import spi_apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter bit PROT_CHECK = 1'b1
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [3:0]            pstrb,
  input  logic [2:0]            pprot,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  tx_push,
  output logic [7:0]            tx_data,
  input  logic                  tx_full,
  output logic                  rx_pop,
  input  logic [7:0]            rx_data,
  input  logic                  rx_empty,
  input  logic                  rx_ovf_set,
  input  logic                  busy,
  output logic                  spi_en,
  output logic                  cpol,
  output logic                  cpha,
  output logic [7:0]            clk_div,
  output logic                  irq
);

  logic [1:0]            reg_sel;
  logic                  acc_err;
  logic                  rd_wait_req;
  logic                  complete;
  logic                  in_rdwait;
  logic                  wr_ok;
  logic                  rd_ok;

  logic [CTRL_LOW_W-1:0] ctrl_q, ctrl_d;
  logic [7:0]            div_q, div_d;
  logic                  rx_ovf_q, rx_ovf_d;
  logic                  irq_q, irq_d;

  // Address bits below the word index and upper data/strobe/prot bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{paddr[1:0], pwdata[DATA_WIDTH-1:16], pstrb[3:2], pprot[2:1]};

  // Decode the held address phase into a register index and an error verdict
  always_comb begin
    reg_sel = paddr[3:2];
    acc_err = (|paddr[ADDR_WIDTH-1:4]) || (PROT_CHECK && !pprot[0]);
    case (reg_sel)
      REG_TXDATA: begin
        if (!pwrite || tx_full || !pstrb[0]) begin
          acc_err = 1'b1;
        end
      end
      REG_RXDATA: begin
        if (pwrite || rx_empty) begin
          acc_err = 1'b1;
        end
      end
      default: begin
      end
    endcase
    rd_wait_req = !acc_err && !pwrite && (reg_sel == REG_RXDATA);
  end

  spi_apb_access_fsm u_fsm (
    .pclk       (pclk),
    .preset_n   (preset_n),
    .psel       (psel),
    .penable    (penable),
    .rd_wait_req(rd_wait_req),
    .pready     (pready),
    .rx_pop     (rx_pop),
    .complete   (complete),
    .in_rdwait  (in_rdwait)
  );

  // The RDWAIT cycle finishes a read that was already vetted and popped, so it is never an error
  assign wr_ok   = complete && !in_rdwait && !acc_err && pwrite;
  assign rd_ok   = complete && !pwrite && (in_rdwait || !acc_err);
  assign pslverr = complete && !in_rdwait && acc_err;

  assign tx_push = wr_ok && (reg_sel == REG_TXDATA);
  assign tx_data = tx_push ? pwdata[7:0] : 8'h00;

  // Register updates on completion; an overflow pulse beats a simultaneous W1C
  always_comb begin
    ctrl_d   = ctrl_q;
    div_d    = div_q;
    rx_ovf_d = rx_ovf_q;
    if (wr_ok && (reg_sel == REG_CTRL)) begin
      if (pstrb[0]) begin
        ctrl_d = pwdata[CTRL_LOW_W-1:0];
      end
      if (pstrb[1]) begin
        div_d = pwdata[CTRL_DIV_LSB +: 8];
      end
    end
    if (wr_ok && (reg_sel == REG_STATUS) && pwdata[STAT_RX_OVF] && pstrb[0]) begin
      rx_ovf_d = 1'b0;
    end
    if (rx_ovf_set) begin
      rx_ovf_d = 1'b1;
    end
    irq_d = (ctrl_q[CTRL_TXIE] && !tx_full) || (ctrl_q[CTRL_RXIE] && !rx_empty) || rx_ovf_q;
  end

  // Read data is only driven on a completing, non-error read
  always_comb begin
    prdata = '0;
    if (rd_ok) begin
      if (in_rdwait) begin
        prdata[7:0] = rx_data;
      end else begin
        case (reg_sel)
          REG_CTRL: begin
            prdata[CTRL_LOW_W-1:0]    = ctrl_q;
            prdata[CTRL_DIV_LSB +: 8] = div_q;
          end
          REG_STATUS: begin
            prdata[STAT_TX_FULL]  = tx_full;
            prdata[STAT_RX_EMPTY] = rx_empty;
            prdata[STAT_BUSY]     = busy;
            prdata[STAT_RX_OVF]   = rx_ovf_q;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Configuration, overflow flag and interrupt storage
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      ctrl_q   <= '0;
      div_q    <= '0;
      rx_ovf_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      div_q    <= div_d;
      rx_ovf_q <= rx_ovf_d;
      irq_q    <= irq_d;
    end
  end

  assign spi_en  = ctrl_q[CTRL_EN];
  assign cpol    = ctrl_q[CTRL_CPOL];
  assign cpha    = ctrl_q[CTRL_CPHA];
  assign clk_div = div_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_spi_apb_slave.sv
// tb/tb_spi_apb_slave.sv - self-checking bench for spi_apb_slave
module tb_spi_apb_slave;

  logic        pclk;
  logic        preset_n;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready, pslverr, tx_push;
  logic [7:0]  tx_data;
  logic        tx_full, rx_pop;
  logic [7:0]  rx_data;
  logic        rx_empty, rx_ovf_set, busy;
  logic        spi_en, cpol, cpha;
  logic [7:0]  clk_div;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Observations of the last transfer
  int          push_cnt, pop_cnt, r_waits;
  logic [7:0]  last_tx;
  logic [31:0] r_data;
  logic        r_err;

  // Reference model of architectural state
  logic [4:0]  m_ctrl;
  logic [7:0]  m_div;
  logic        m_ovf;

  spi_apb_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .PROT_CHECK(1'b1)
  ) dut (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .pprot     (pprot),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .tx_push   (tx_push),
    .tx_data   (tx_data),
    .tx_full   (tx_full),
    .rx_pop    (rx_pop),
    .rx_data   (rx_data),
    .rx_empty  (rx_empty),
    .rx_ovf_set(rx_ovf_set),
    .busy      (busy),
    .spi_en    (spi_en),
    .cpol      (cpol),
    .cpha      (cpha),
    .clk_div   (clk_div),
    .irq       (irq)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One APB transfer; samples strobes and response 1 ns after each driving edge
  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input logic [2:0] prot, input logic ovf_pulse);
    push_cnt = 0;
    pop_cnt  = 0;
    last_tx  = 8'h00;
    r_waits  = 0;
    r_data   = 'x;
    r_err    = 1'bx;
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = data; pstrb = strb; pprot = prot;
    #1;
    if (tx_push) push_cnt++;
    if (rx_pop) pop_cnt++;
    @(negedge pclk);
    penable = 1'b1;
    rx_ovf_set = ovf_pulse;
    forever begin
      #1;
      if (tx_push) begin
        push_cnt++;
        last_tx = tx_data;
      end
      if (rx_pop) pop_cnt++;
      if (pready) begin
        r_data = prdata;
        r_err  = pslverr;
        break;
      end
      r_waits++;
      if (r_waits > 4) begin
        chk("timeout_waits", 32'(r_waits), 32'd1);
        break;
      end
      @(negedge pclk);
      rx_ovf_set = 1'b0;
    end
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; rx_ovf_set = 1'b0;
  endtask

  // Predict the response from the register rules, run the transfer, compare, update the model
  task automatic xfer_check(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb,
                            input logic [2:0] prot, input logic ovf_pulse);
    logic [1:0]  idx;
    logic        bad, exp_push, exp_wait;
    logic [31:0] exp_rd;
    idx = addr[3:2];
    bad = (addr[31:4] != 28'h0) || !prot[0]
        || (wr && idx == 2'd3) || (!wr && idx == 2'd2)
        || (!wr && idx == 2'd3 && rx_empty)
        || (wr && idx == 2'd2 && (tx_full || !strb[0]));
    exp_push = !bad && wr && idx == 2'd2;
    exp_wait = !bad && !wr && idx == 2'd3;
    exp_rd   = 32'h0;
    if (!bad && !wr) begin
      case (idx)
        2'd0:    exp_rd = {16'h0, m_div, 3'b000, m_ctrl};
        2'd1:    exp_rd = {28'h0, m_ovf, busy, rx_empty, tx_full};
        2'd3:    exp_rd = {24'h0, rx_data};
        default: exp_rd = 32'h0;
      endcase
    end
    apb(wr, addr, data, strb, prot, ovf_pulse);
    chk({tag, "_slverr"}, 32'(r_err), 32'(bad));
    chk({tag, "_waits"}, 32'(r_waits), 32'(exp_wait));
    chk({tag, "_pop"}, 32'(pop_cnt), 32'(exp_wait));
    chk({tag, "_push"}, 32'(push_cnt), 32'(exp_push));
    if (exp_push) chk({tag, "_txdata"}, 32'(last_tx), 32'(data[7:0]));
    if (!wr) chk({tag, "_prdata"}, r_data, exp_rd);
    if (!bad && wr && idx == 2'd0) begin
      if (strb[0]) m_ctrl = data[4:0];
      if (strb[1]) m_div = data[15:8];
    end
    if (!bad && wr && idx == 2'd1 && data[3] && strb[0]) m_ovf = 1'b0;
    if (ovf_pulse) m_ovf = 1'b1;
    chk({tag, "_ctrl"}, 32'({clk_div, cpha, cpol, spi_en}), 32'({m_div, m_ctrl[2:0]}));
    @(negedge pclk);
    chk({tag, "_irq"}, 32'(irq),
        32'((m_ctrl[3] && !tx_full) || (m_ctrl[4] && !rx_empty) || m_ovf));
  endtask

  task automatic ovf_pulse_alone();
    @(negedge pclk);
    rx_ovf_set = 1'b1;
    @(negedge pclk);
    rx_ovf_set = 1'b0;
    m_ovf = 1'b1;
  endtask

  logic        t_wr, t_ovf;
  logic [31:0] t_addr, t_data;
  logic [3:0]  t_strb;
  logic [2:0]  t_prot;

  initial begin
    preset_n = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    pstrb = '0; pprot = '0;
    tx_full = 1'b0; rx_empty = 1'b1; rx_data = 8'h00; rx_ovf_set = 1'b0; busy = 1'b0;
    m_ctrl = '0; m_div = '0; m_ovf = 1'b0;

    repeat (3) @(negedge pclk);
    chk("reset_outs", 32'({pready, pslverr, tx_push, rx_pop, spi_en, cpol, cpha, irq}), 32'h0);
    chk("reset_prdata", prdata, 32'h0);
    chk("reset_txdata_div", 32'({tx_data, clk_div}), 32'h0);
    preset_n = 1'b1;
    @(negedge pclk);

    // CTRL write with byte strobes 0 and 1, then readback
    xfer_check("ctrl_wr", 1'b1, 32'h0, 32'h0000_3F07, 4'b0011, 3'b001, 1'b0);
    chk("ctrl_outs", 32'({spi_en, cpol, cpha, clk_div}), 32'({3'b111, 8'h3F}));
    xfer_check("ctrl_rd", 1'b0, 32'h0, 32'h0, 4'b0000, 3'b001, 1'b0);
    chk("ctrl_rd_value", r_data, 32'h0000_3F07);

    // TX push, then TX full refusal
    tx_full = 1'b0;
    xfer_check("tx_ok", 1'b1, 32'h8, 32'h0000_00A5, 4'b0001, 3'b001, 1'b0);
    tx_full = 1'b1;
    xfer_check("tx_full", 1'b1, 32'h8, 32'h0000_00A5, 4'b0001, 3'b001, 1'b0);

    // RX read with one wait state, then empty refusal
    rx_data = 8'h5A; rx_empty = 1'b0;
    xfer_check("rx_ok", 1'b0, 32'hC, 32'h0, 4'b0000, 3'b001, 1'b0);
    chk("rx_ok_value", r_data, 32'h0000_005A);
    rx_empty = 1'b1;
    xfer_check("rx_empty", 1'b0, 32'hC, 32'h0, 4'b0000, 3'b001, 1'b0);

    // Overflow flag, irq, W1C racing a new pulse, plain W1C
    ovf_pulse_alone();
    xfer_check("ovf_rd", 1'b0, 32'h4, 32'h0, 4'b0000, 3'b001, 1'b0);
    xfer_check("ovf_race", 1'b1, 32'h4, 32'h8, 4'b0001, 3'b001, 1'b1);
    xfer_check("ovf_race_rd", 1'b0, 32'h4, 32'h0, 4'b0000, 3'b001, 1'b0);
    xfer_check("ovf_clr", 1'b1, 32'h4, 32'h8, 4'b0001, 3'b001, 1'b0);
    xfer_check("ovf_clr_rd", 1'b0, 32'h4, 32'h0, 4'b0000, 3'b001, 1'b0);

    // Out-of-map and unprivileged accesses
    xfer_check("hi_addr", 1'b0, 32'h10, 32'h0, 4'b0000, 3'b001, 1'b0);
    xfer_check("unpriv_wr", 1'b1, 32'h0, 32'h0000_FFFF, 4'b1111, 3'b000, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      tx_full  = 1'($urandom);
      rx_empty = 1'($urandom);
      busy     = 1'($urandom);
      rx_data  = 8'($urandom);
      if ($urandom_range(0, 4) == 0) ovf_pulse_alone();
      t_wr   = 1'($urandom);
      t_addr = {28'h0, 2'($urandom), 2'($urandom)};
      if ($urandom_range(0, 7) == 0) t_addr[31:4] = 28'($urandom_range(1, 32'h0FFF_FFFF));
      t_data = $urandom;
      t_strb = 4'($urandom);
      if ($urandom_range(0, 3) != 0) t_strb[0] = 1'b1;
      if (!t_wr) t_strb = 4'b0000;
      t_prot = 3'($urandom);
      if ($urandom_range(0, 5) != 0) t_prot[0] = 1'b1;
      t_ovf = t_wr && ($urandom_range(0, 5) == 0);
      xfer_check($sformatf("rand%0d", i), t_wr, t_addr, t_data, t_strb, t_prot, t_ovf);
    end

    // Reset while the RX read sits in its wait state
    tx_full = 1'b0; busy = 1'b0;
    xfer_check("pre_rst_ctrl", 1'b1, 32'h0, 32'h0000_2107, 4'b0011, 3'b001, 1'b0);
    rx_data = 8'h3C; rx_empty = 1'b0;
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'hC; pstrb = 4'b0000; pprot = 3'b001;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    chk("mid_pop", 32'({rx_pop, pready}), 32'({1'b1, 1'b0}));
    @(posedge pclk);
    #1;
    chk("mid_rdwait_pready", 32'({pready, rx_pop}), 32'({1'b1, 1'b0}));
    preset_n = 1'b0;
    #1;
    chk("mid_rst_outs", 32'({pready, rx_pop, pslverr, spi_en, cpol, cpha, clk_div}), 32'h0);
    chk("mid_rst_prdata", prdata, 32'h0);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    preset_n = 1'b1;
    m_ctrl = '0; m_div = '0; m_ovf = 1'b0;
    rx_empty = 1'b1;
    xfer_check("post_rst_rd", 1'b0, 32'h0, 32'h0, 4'b0000, 3'b001, 1'b0);
    xfer_check("post_rst_wr", 1'b1, 32'h0, 32'h0000_1203, 4'b0011, 3'b001, 1'b0);
    xfer_check("post_rst_rb", 1'b0, 32'h0, 32'h0, 4'b0000, 3'b001, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
